keypad_debounce: RTL and testbench



---
 rtl/keypad_debounce.sv | 140 ++++++++++++++
 tb/tb_keypad_debounce.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
// keypad_debounce: debounces the 5-bit keypad scanner code.
// It emits one key_valid pulse per physical press.
// It keeps the last two accepted keys for the dual seven-segment display.
// Code convention: bit4 set means "no key", otherwise [3:0] is the key value.
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] button,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       held
);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    cand_r;
  logic          key_valid_r;
  logic [3:0]    digit_new_r;
  logic [3:0]    digit_old_r;
  logic          held_r;

  logic          valid_s;
  logic          match_s;
  logic          cnt_last_s;

  // Decode the current sample against the candidate key and the counter limit.
  always_comb begin
    valid_s    = 1'b0;
    match_s    = 1'b0;
    cnt_last_s = 1'b0;
    if (button[4] == 1'b0) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    if (button == {1'b0, cand_r}) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
    if (cnt_r == CNT_LAST) begin
      cnt_last_s = 1'b1;
    end else begin
      cnt_last_s = 1'b0;
    end
  end

  // Debounce FSM. Every output is a register that updates on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      cand_r      <= 4'h0;
      key_valid_r <= 1'b0;
      digit_new_r <= 4'h0;
      digit_old_r <= 4'h0;
      held_r      <= 1'b0;
    end else begin
      // key_valid is a single-cycle strobe and only the acceptance arm raises it.
      key_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_s) begin
            cand_r  <= button[3:0];
            cnt_r   <= CNT_ZERO;
            state_r <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (match_s) begin
            if (cnt_last_s) begin
              // DEBOUNCE_CYCLES+1 matching samples seen: accept the key.
              state_r     <= ST_PRESSED;
              key_valid_r <= 1'b1;
              digit_old_r <= digit_new_r;
              digit_new_r <= cand_r;
              held_r      <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            // A different key or no key means a bounce, so start over without a pulse.
            cnt_r   <= CNT_ZERO;
            state_r <= ST_IDLE;
          end
        end

        ST_PRESSED: begin
          // Any valid code keeps the press alive. A second key pressed while one is held is ignored.
          if (!valid_s) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (valid_s) begin
            // A valid code here is release bounce: return to PRESSED without a new pulse.
            cnt_r   <= CNT_ZERO;
            state_r <= ST_PRESSED;
          end else if (cnt_last_s) begin
            state_r <= ST_IDLE;
            held_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          held_r  <= 1'b0;
        end
      endcase
    end
  end

  assign key_valid = key_valid_r;
  assign digit_new = digit_new_r;
  assign digit_old = digit_old_r;
  assign held      = held_r;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed testbench for keypad_debounce with DEBOUNCE_CYCLES=4.
// One press is accepted on its 5th consecutive matching sample.
// A release completes on its 5th consecutive no-key sample.
module tb_keypad_debounce;

  logic       clk;
  logic       reset;
  logic [4:0] button;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       held;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int doubles  = 0;
  logic prev_kv = 1'b0;

  keypad_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .key_valid (key_valid),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .held      (held)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply code b for n clock edges. Outputs are sampled 1 ns after each edge.
  task automatic drive(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      button = b;
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) pulses++;
      if (key_valid === 1'b1 && prev_kv === 1'b1) doubles++;
      prev_kv = key_valid;
    end
  endtask

  task automatic check_outputs(input string tag, input logic kv, input logic [3:0] dn,
                               input logic [3:0] dold, input logic h);
    chk_eq({tag, "_kv"},   32'(key_valid), 32'(kv));
    chk_eq({tag, "_new"},  32'(digit_new), 32'(dn));
    chk_eq({tag, "_old"},  32'(digit_old), 32'(dold));
    chk_eq({tag, "_held"}, 32'(held),      32'(h));
  endtask

  initial begin
    reset  = 1'b0;
    button = 5'h10;
    drive(5'h10, 2);
    check_outputs("reset", 1'b0, 4'h0, 4'h0, 1'b0);
    reset = 1'b1;

    // Clean press of 5: key_valid appears only after the 5th sample.
    pulses = 0;
    drive(5'h05, 4);
    chk_eq("clean_early", 32'(pulses), 32'd0);
    drive(5'h05, 1);
    chk_eq("clean_kv_edge4", 32'(key_valid), 32'd1);
    drive(5'h05, 1);
    chk_eq("clean_kv_drop", 32'(key_valid), 32'd0);
    drive(5'h05, 4);
    chk_eq("clean_pulses", 32'(pulses), 32'd1);
    check_outputs("clean", 1'b0, 4'h5, 4'h0, 1'b1);
    drive(5'h10, 4);
    chk_eq("release_not_done", 32'(held), 32'd1);
    drive(5'h10, 2);
    check_outputs("released", 1'b0, 4'h5, 4'h0, 1'b0);

    // Press bounce on 7 produces no pulse until 5 steady samples.
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      drive(5'h07, 2);
      drive(5'h10, 2);
    end
    chk_eq("bounce_none", 32'(pulses), 32'd0);
    chk_eq("bounce_held", 32'(held), 32'd0);
    drive(5'h07, 4);
    chk_eq("bounce_early", 32'(pulses), 32'd0);
    drive(5'h07, 1);
    chk_eq("bounce_kv", 32'(key_valid), 32'd1);
    drive(5'h07, 3);
    chk_eq("bounce_pulses", 32'(pulses), 32'd1);
    check_outputs("bounce", 1'b0, 4'h7, 4'h5, 1'b1);
    drive(5'h10, 6);

    // Release bounce on 3 gives one pulse, followed by a press of A.
    pulses = 0;
    drive(5'h03, 6);
    chk_eq("rb_accept3", 32'(pulses), 32'd1);
    drive(5'h10, 2);
    drive(5'h03, 1);
    chk_eq("rb_held_bounce", 32'(held), 32'd1);
    drive(5'h10, 6);
    chk_eq("rb_one_pulse", 32'(pulses), 32'd1);
    check_outputs("rb_released", 1'b0, 4'h3, 4'h7, 1'b0);
    drive(5'h0A, 6);
    chk_eq("rb_pulses_a", 32'(pulses), 32'd2);
    check_outputs("rb_a", 1'b0, 4'hA, 4'h3, 1'b1);
    drive(5'h10, 6);

    // Key change while held is ignored.
    pulses = 0;
    drive(5'h01, 6);
    drive(5'h02, 8);
    chk_eq("chg_pulses", 32'(pulses), 32'd1);
    check_outputs("chg", 1'b0, 4'h1, 4'hA, 1'b1);
    drive(5'h10, 6);
    chk_eq("chg_released", 32'(held), 32'd0);

    // The glitch code 0x1F counts as no key.
    pulses = 0;
    drive(5'h1F, 10);
    chk_eq("glitch_pulses", 32'(pulses), 32'd0);
    check_outputs("glitch", 1'b0, 4'h1, 4'hA, 1'b0);

    // Reset during CHECK while cnt is 2.
    drive(5'h09, 3);
    reset = 1'b0;
    drive(5'h09, 1);
    check_outputs("rst_check", 1'b0, 4'h0, 4'h0, 1'b0);
    reset = 1'b1;
    drive(5'h10, 2);

    // Reach digits 9/4 in PRESSED, then apply reset.
    drive(5'h04, 6);
    drive(5'h10, 6);
    drive(5'h09, 6);
    check_outputs("pre_rst", 1'b0, 4'h9, 4'h4, 1'b1);
    reset = 1'b0;
    drive(5'h09, 1);
    check_outputs("rst_pressed", 1'b0, 4'h0, 4'h0, 1'b0);
    reset = 1'b1;
    drive(5'h10, 2);

    // A clean press of E after reset, starting from IDLE.
    pulses = 0;
    drive(5'h0E, 4);
    chk_eq("e_early", 32'(pulses), 32'd0);
    drive(5'h0E, 1);
    chk_eq("e_kv", 32'(key_valid), 32'd1);
    drive(5'h0E, 2);
    check_outputs("e_final", 1'b0, 4'hE, 4'h0, 1'b1);

    chk_eq("no_double_pulse", 32'(doubles), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
